bmem_arbiter: RTL and testbench

BMEM_ARBITER -- requirements
Module: bmem_arbiter

---
 rtl/bmem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_bmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_arbiter.sv
// bmem_arbiter
// Shares one banked-memory port between an icache (read-only) and a dcache
// (read + writeback). Line size is 256 bits, moved as 4 beats of 64 bits,
// beat k occupying line bits [64k+63:64k].
//
// Reads are split into an issue phase (a single accepted request) and a return
// phase. Memory may return beats for different lines out of order. Each client
// tracks its own outstanding read and assembles its line from beats whose
// return address matches. Writes occupy the port for four accepted beats.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_addr, i_read           icache line request
//   i_rdata, i_resp          icache returned line, one-cycle completion pulse
//   d_addr, d_read, d_write  dcache request (write wins if both are high)
//   d_wdata                  dcache writeback line
//   d_rdata, d_resp          dcache returned line, one-cycle completion pulse
//   bmem_addr/read/write     memory request (addr bits [4:0] always 0)
//   bmem_wdata               current write beat
//   bmem_ready               memory accepts the current read or write beat
//   bmem_raddr/rdata/rvalid  read-return beat, tagged with its line address
module bmem_arbiter #(
    parameter logic DFIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  i_addr,
    input  logic         i_read,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic [31:0]  d_addr,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);

    localparam logic IDLE  = 1'b0;
    localparam logic WRITE = 1'b1;
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    logic         state;
    logic [1:0]   wcnt;
    logic [31:0]  waddr;

    logic         i_out, d_out;
    logic [31:0]  i_cap, d_cap;
    logic [1:0]   i_cnt, d_cnt;
    logic [255:0] i_buf, d_buf;

    logic         rst_q;
    logic         lock_valid;
    logic         lock_d;

    logic         i_elig, d_elig;
    logic         sel_valid, sel_d;
    logic         blocked;
    logic         issue, issue_write, issue_read;
    logic         i_hit, d_hit;
    logic [255:0] i_line, d_line;

    // Arbitration and the combinational memory request. A read stalled by
    // bmem_ready=0 locks the grant so the address cannot change under the
    // memory. The port stays quiet during reset and the cycle that follows it.
    always_comb begin
        i_elig = i_read && !i_out && !i_resp;
        d_elig = (d_read || d_write) && !d_out && !d_resp;

        sel_valid = 1'b0;
        sel_d     = 1'b0;
        if (lock_valid && (lock_d ? d_elig : i_elig)) begin
            sel_valid = 1'b1;
            sel_d     = lock_d;
        end else if (i_elig || d_elig) begin
            sel_valid = 1'b1;
            sel_d     = d_elig && (DFIRST || !i_elig);
        end

        blocked     = rst || rst_q;
        issue       = (state == IDLE) && !blocked && sel_valid;
        issue_write = issue && sel_d && d_write;
        issue_read  = issue && !issue_write;

        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = 32'd0;
        bmem_wdata = 64'd0;
        if (!blocked) begin
            if (state == WRITE) begin
                bmem_write = 1'b1;
                bmem_addr  = waddr;
                bmem_wdata = d_wdata[{wcnt, 6'd0} +: 64];
            end else if (issue_write) begin
                bmem_write = 1'b1;
                bmem_addr  = d_addr & LINE_MASK;
                bmem_wdata = d_wdata[{wcnt, 6'd0} +: 64];
            end else if (issue_read) begin
                bmem_read = 1'b1;
                bmem_addr = (sel_d ? d_addr : i_addr) & LINE_MASK;
            end
        end
    end

    // Return-beat matching. The next assembly buffer is formed here so the
    // final beat can be folded straight into the completed line.
    always_comb begin
        i_hit  = bmem_rvalid && i_out && (((i_cap ^ bmem_raddr) & LINE_MASK) == 32'd0);
        d_hit  = bmem_rvalid && d_out && (((d_cap ^ bmem_raddr) & LINE_MASK) == 32'd0);
        i_line = i_buf;
        i_line[{i_cnt, 6'd0} +: 64] = bmem_rdata;
        d_line = d_buf;
        d_line[{d_cnt, 6'd0} +: 64] = bmem_rdata;
    end

    // Issue bookkeeping, write sequencing and per-client line assembly.
    // Issue needs a client with no outstanding read while a return needs one
    // with an outstanding read, so the two never touch the same client state
    // in the same cycle. The write path only runs with no dcache read pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wcnt       <= 2'd0;
            waddr      <= 32'd0;
            i_out      <= 1'b0;
            d_out      <= 1'b0;
            i_cap      <= 32'd0;
            d_cap      <= 32'd0;
            i_cnt      <= 2'd0;
            d_cnt      <= 2'd0;
            i_buf      <= 256'd0;
            d_buf      <= 256'd0;
            i_rdata    <= 256'd0;
            d_rdata    <= 256'd0;
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
            lock_valid <= 1'b0;
            lock_d     <= 1'b0;
            rst_q      <= 1'b1;
        end else begin
            rst_q      <= 1'b0;
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
            lock_valid <= issue_read && !bmem_ready;
            lock_d     <= sel_d;

            if (issue_read && bmem_ready) begin
                if (sel_d) begin
                    d_out <= 1'b1;
                    d_cap <= bmem_addr;
                    d_cnt <= 2'd0;
                end else begin
                    i_out <= 1'b1;
                    i_cap <= bmem_addr;
                    i_cnt <= 2'd0;
                end
            end

            case (state)
                IDLE: begin
                    if (issue_write) begin
                        state <= WRITE;
                        waddr <= bmem_addr;
                        wcnt  <= bmem_ready ? 2'd1 : 2'd0;
                    end
                end
                WRITE: begin
                    if (bmem_ready) begin
                        wcnt <= wcnt + 2'd1;
                        if (wcnt == 2'd3) begin
                            state  <= IDLE;
                            d_resp <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (i_hit) begin
                i_buf <= i_line;
                i_cnt <= i_cnt + 2'd1;
                if (i_cnt == 2'd3) begin
                    i_out   <= 1'b0;
                    i_cnt   <= 2'd0;
                    i_rdata <= i_line;
                    i_resp  <= 1'b1;
                end
            end

            if (d_hit) begin
                d_buf <= d_line;
                d_cnt <= d_cnt + 2'd1;
                if (d_cnt == 2'd3) begin
                    d_out   <= 1'b0;
                    d_cnt   <= 2'd0;
                    d_rdata <= d_line;
                    d_resp  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bmem_arbiter.sv
// tb_bmem_arbiter
// Directed bench for bmem_arbiter (DFIRST=1). Each scenario task drives
// inputs just after a rising edge and compares outputs a step later, so
// samples never land on the active edge. Expected values are hand-derived
// constants.
module tb_bmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int checks = 0;
    int errors = 0;

    // Line patterns used as memory return data and writeback data.
    logic [255:0] line_a = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
                            64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    logic [255:0] line_i = {64'h1111_0000_0000_0013, 64'h1111_0000_0000_0012,
                            64'h1111_0000_0000_0011, 64'h1111_0000_0000_0010};
    logic [255:0] line_d = {64'h2222_0000_0000_0023, 64'h2222_0000_0000_0022,
                            64'h2222_0000_0000_0021, 64'h2222_0000_0000_0020};
    logic [255:0] line_e = {64'h3333_0000_0000_0033, 64'h3333_0000_0000_0032,
                            64'h3333_0000_0000_0031, 64'h3333_0000_0000_0030};
    logic [255:0] line_f = {64'h4444_0000_0000_0043, 64'h4444_0000_0000_0042,
                            64'h4444_0000_0000_0041, 64'h4444_0000_0000_0040};
    logic [255:0] line_w = {64'h5555_0000_0000_0053, 64'h5555_0000_0000_0052,
                            64'h5555_0000_0000_0051, 64'h5555_0000_0000_0050};
    logic [255:0] line_s = {64'h6666_0000_0000_0063, 64'h6666_0000_0000_0062,
                            64'h6666_0000_0000_0061, 64'h6666_0000_0000_0060};
    logic [255:0] line_g = {64'h7777_0000_0000_0073, 64'h7777_0000_0000_0072,
                            64'h7777_0000_0000_0071, 64'h7777_0000_0000_0070};
    logic [255:0] line_h = {64'h8888_0000_0000_0083, 64'h8888_0000_0000_0082,
                            64'h8888_0000_0000_0081, 64'h8888_0000_0000_0080};
    logic [255:0] line_j = {64'h9999_0000_0000_0093, 64'h9999_0000_0000_0092,
                            64'h9999_0000_0000_0091, 64'h9999_0000_0000_0090};

    always #5 clk = ~clk;

    bmem_arbiter #(.DFIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One return beat presented for a single cycle.
    task automatic beat(input logic [31:0] a, input logic [63:0] d);
        bmem_rvalid = 1'b1;
        bmem_raddr  = a;
        bmem_rdata  = d;
        tick();
        bmem_rvalid = 1'b0;
        bmem_raddr  = 32'd0;
        bmem_rdata  = 64'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_read = 1'b1; d_read = 1'b1;
        i_addr = 32'h0000_1040; d_addr = 32'h0000_2040; bmem_ready = 1'b1;
        #1;
        checks++; if (bmem_read !== 1'b0) begin errors++; $display("[TB] FAIL rst_read got %b want 0", bmem_read); end
        checks++; if (bmem_addr !== 32'd0) begin errors++; $display("[TB] FAIL rst_addr got %h want 0", bmem_addr); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bmem_read !== 1'b0 || bmem_write !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_quiet got r=%b w=%b want 0 0", bmem_read, bmem_write); end
        checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp got i=%b d=%b want 0 0", i_resp, d_resp); end
        checks++; if (i_rdata !== 256'd0 || d_rdata !== 256'd0) begin errors++; $display("[TB] FAIL rst_rdata got i=%h d=%h want 0", i_rdata, d_rdata); end
        i_read = 1'b0; d_read = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        i_addr = 32'h0000_1040; i_read = 1'b1; bmem_ready = 1'b1;
        #1;
        checks++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_1040) begin errors++; $display("[TB] FAIL single_issue got r=%b a=%h want 1 00001040", bmem_read, bmem_addr); end
        tick(); #1;
        checks++; if (bmem_read !== 1'b0) begin errors++; $display("[TB] FAIL single_one_cycle got %b want 0", bmem_read); end
        for (int k = 0; k < 3; k++) beat(32'h0000_1040 + 32'(k * 8), line_a[k*64 +: 64]);
        #1;
        checks++; if (i_resp !== 1'b0) begin errors++; $display("[TB] FAIL single_early_resp got %b want 0", i_resp); end
        beat(32'h0000_105F, line_a[255:192]);
        #1;
        checks++; if (i_resp !== 1'b1) begin errors++; $display("[TB] FAIL single_resp got %b want 1", i_resp); end
        checks++; if (i_rdata !== line_a) begin errors++; $display("[TB] FAIL single_rdata got %h want %h", i_rdata, line_a); end
        checks++; if (bmem_read !== 1'b0) begin errors++; $display("[TB] FAIL resp_blocks_issue got %b want 0", bmem_read); end
        i_read = 1'b0;
        tick(); #1;
        checks++; if (i_resp !== 1'b0) begin errors++; $display("[TB] FAIL single_resp_pulse got %b want 0", i_resp); end
    endtask

    task automatic test_dfirst_priority();
        i_addr = 32'h0000_4000; d_addr = 32'h0000_5000;
        i_read = 1'b1; d_read = 1'b1; bmem_ready = 1'b1;
        #1;
        checks++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_5000) begin errors++; $display("[TB] FAIL prio_first got r=%b a=%h want 1 00005000", bmem_read, bmem_addr); end
        tick(); #1;
        checks++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_4000) begin errors++; $display("[TB] FAIL prio_second got r=%b a=%h want 1 00004000", bmem_read, bmem_addr); end
        tick(); #1;
        checks++; if (bmem_read !== 1'b0) begin errors++; $display("[TB] FAIL prio_idle got %b want 0", bmem_read); end
        for (int k = 0; k < 4; k++) beat(32'h0000_4000 + 32'(k * 8), line_i[k*64 +: 64]);
        #1;
        checks++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin errors++; $display("[TB] FAIL prio_i_resp got i=%b d=%b want 1 0", i_resp, d_resp); end
        checks++; if (i_rdata !== line_i) begin errors++; $display("[TB] FAIL prio_i_rdata got %h want %h", i_rdata, line_i); end
        i_read = 1'b0;
        for (int k = 0; k < 4; k++) beat(32'h0000_5000, line_d[k*64 +: 64]);
        #1;
        checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin errors++; $display("[TB] FAIL prio_d_resp got d=%b i=%b want 1 0", d_resp, i_resp); end
        checks++; if (d_rdata !== line_d) begin errors++; $display("[TB] FAIL prio_d_rdata got %h want %h", d_rdata, line_d); end
        d_read = 1'b0;
        tick();
    endtask

    task automatic test_stall_lock();
        i_addr = 32'h0000_A020; i_read = 1'b1; bmem_ready = 1'b0;
        #1;
        checks++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_A020) begin errors++; $display("[TB] FAIL lock_issue got r=%b a=%h want 1 0000a020", bmem_read, bmem_addr); end
        tick();
        d_addr = 32'h0000_B000; d_read = 1'b1;
        #1;
        checks++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_A020) begin errors++; $display("[TB] FAIL lock_hold got r=%b a=%h want 1 0000a020", bmem_read, bmem_addr); end
        tick();
        bmem_ready = 1'b1;
        #1;
        checks++; if (bmem_addr !== 32'h0000_A020) begin errors++; $display("[TB] FAIL lock_accept got %h want 0000a020", bmem_addr); end
        tick(); #1;
        checks++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_B000) begin errors++; $display("[TB] FAIL lock_next got r=%b a=%h want 1 0000b000", bmem_read, bmem_addr); end
        tick(); #1;
        checks++; if (bmem_read !== 1'b0) begin errors++; $display("[TB] FAIL lock_idle got %b want 0", bmem_read); end
        for (int k = 0; k < 4; k++) beat(32'h0000_B000, line_e[k*64 +: 64]);
        #1;
        checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== line_e) begin errors++; $display("[TB] FAIL lock_d_ret got d=%b i=%b data=%h want 1 0 %h", d_resp, i_resp, d_rdata, line_e); end
        d_read = 1'b0;
        for (int k = 0; k < 4; k++) beat(32'h0000_A020, line_f[k*64 +: 64]);
        #1;
        checks++; if (i_resp !== 1'b1 || i_rdata !== line_f) begin errors++; $display("[TB] FAIL lock_i_ret got i=%b data=%h want 1 %h", i_resp, i_rdata, line_f); end
        i_read = 1'b0;
        tick();
    endtask

    task automatic test_write_stall();
        d_addr = 32'h0000_2000; d_wdata = line_w; d_write = 1'b1; d_read = 1'b1; bmem_ready = 1'b1;
        #1;
        checks++; if (bmem_write !== 1'b1 || bmem_read !== 1'b0 || bmem_addr !== 32'h0000_2000) begin errors++; $display("[TB] FAIL wr_issue got w=%b r=%b a=%h want 1 0 00002000", bmem_write, bmem_read, bmem_addr); end
        checks++; if (bmem_wdata !== line_w[63:0]) begin errors++; $display("[TB] FAIL wr_beat0 got %h want %h", bmem_wdata, line_w[63:0]); end
        tick(); #1;
        checks++; if (bmem_wdata !== line_w[127:64]) begin errors++; $display("[TB] FAIL wr_beat1 got %h want %h", bmem_wdata, line_w[127:64]); end
        tick();
        bmem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bmem_write !== 1'b1 || bmem_addr !== 32'h0000_2000 || bmem_wdata !== line_w[191:128]) begin errors++; $display("[TB] FAIL wr_stall%0d got w=%b a=%h d=%h want 1 00002000 %h", c, bmem_write, bmem_addr, bmem_wdata, line_w[191:128]); end
            tick();
        end
        bmem_ready = 1'b1;
        #1;
        checks++; if (bmem_wdata !== line_w[191:128]) begin errors++; $display("[TB] FAIL wr_beat2 got %h want %h", bmem_wdata, line_w[191:128]); end
        tick(); #1;
        checks++; if (bmem_wdata !== line_w[255:192] || d_resp !== 1'b0) begin errors++; $display("[TB] FAIL wr_beat3 got d=%h resp=%b want %h 0", bmem_wdata, d_resp, line_w[255:192]); end
        tick(); #1;
        checks++; if (d_resp !== 1'b1 || bmem_write !== 1'b0) begin errors++; $display("[TB] FAIL wr_resp got resp=%b w=%b want 1 0", d_resp, bmem_write); end
        checks++; if (d_rdata !== line_e) begin errors++; $display("[TB] FAIL wr_rdata_hold got %h want %h", d_rdata, line_e); end
        d_write = 1'b0; d_read = 1'b0;
        tick(); #1;
        checks++; if (d_resp !== 1'b0) begin errors++; $display("[TB] FAIL wr_resp_pulse got %b want 0", d_resp); end
    endtask

    task automatic test_shared();
        i_addr = 32'h0000_3000; d_addr = 32'h0000_3000; i_read = 1'b1; d_read = 1'b1; bmem_ready = 1'b1;
        tick(); tick(); #1;
        checks++; if (bmem_read !== 1'b0) begin errors++; $display("[TB] FAIL shared_idle got %b want 0", bmem_read); end
        for (int k = 0; k < 4; k++) beat(32'h0000_3000 + 32'(k * 8), line_s[k*64 +: 64]);
        #1;
        checks++; if (i_resp !== 1'b1 || d_resp !== 1'b1) begin errors++; $display("[TB] FAIL shared_resp got i=%b d=%b want 1 1", i_resp, d_resp); end
        checks++; if (i_rdata !== line_s || d_rdata !== line_s) begin errors++; $display("[TB] FAIL shared_rdata got i=%h d=%h want %h", i_rdata, d_rdata, line_s); end
        i_read = 1'b0; d_read = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        i_addr = 32'h0000_6000; i_read = 1'b1; bmem_ready = 1'b1;
        tick();
        i_read = 1'b0;
        beat(32'h0000_6000, line_g[63:0]);
        beat(32'h0000_6008, line_g[127:64]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (i_rdata !== 256'd0 || d_rdata !== 256'd0 || i_resp !== 1'b0) begin errors++; $display("[TB] FAIL midrst_outputs got i=%h d=%h resp=%b want 0", i_rdata, d_rdata, i_resp); end
        beat(32'h0000_6010, line_g[191:128]);
        beat(32'h0000_6018, line_g[255:192]);
        #1;
        checks++; if (i_resp !== 1'b0 || i_rdata !== 256'd0) begin errors++; $display("[TB] FAIL midrst_late got resp=%b data=%h want 0 0", i_resp, i_rdata); end
        i_addr = 32'h0000_7000; i_read = 1'b1;
        #1;
        checks++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_7000) begin errors++; $display("[TB] FAIL midrst_new got r=%b a=%h want 1 00007000", bmem_read, bmem_addr); end
        tick();
        for (int k = 0; k < 4; k++) beat(32'h0000_7000, line_h[k*64 +: 64]);
        #1;
        checks++; if (i_resp !== 1'b1 || i_rdata !== line_h) begin errors++; $display("[TB] FAIL midrst_done got resp=%b data=%h want 1 %h", i_resp, i_rdata, line_h); end
        i_read = 1'b0;
        tick();
    endtask

    task automatic test_stray();
        for (int k = 0; k < 4; k++) beat(32'h0000_9000, line_j[k*64 +: 64]);
        #1;
        checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin errors++; $display("[TB] FAIL stray_resp got i=%b d=%b want 0 0", i_resp, d_resp); end
        checks++; if (i_rdata !== line_h || d_rdata !== 256'd0) begin errors++; $display("[TB] FAIL stray_hold got i=%h d=%h", i_rdata, d_rdata); end
        i_addr = 32'h0000_901F; i_read = 1'b1;
        #1;
        checks++; if (bmem_addr !== 32'h0000_9000) begin errors++; $display("[TB] FAIL stray_mask got %h want 00009000", bmem_addr); end
        tick();
        i_read = 1'b0;
        for (int k = 0; k < 3; k++) beat(32'h0000_9000, line_j[k*64 +: 64]);
        #1;
        checks++; if (i_resp !== 1'b0) begin errors++; $display("[TB] FAIL stray_count got %b want 0", i_resp); end
        beat(32'h0000_9000, line_j[255:192]);
        #1;
        checks++; if (i_resp !== 1'b1 || i_rdata !== line_j) begin errors++; $display("[TB] FAIL stray_done got resp=%b data=%h want 1 %h", i_resp, i_rdata, line_j); end
        tick();
    endtask

    // Scenario sequence; each task leaves the bench just after a rising edge.
    initial begin
        rst = 1'b0; i_addr = 32'd0; i_read = 1'b0; d_addr = 32'd0; d_read = 1'b0;
        d_write = 1'b0; d_wdata = 256'd0; bmem_ready = 1'b0; bmem_raddr = 32'd0;
        bmem_rdata = 64'd0; bmem_rvalid = 1'b0;
        #2;
        test_reset();
        test_single_read();
        test_dfirst_priority();
        test_stall_lock();
        test_write_stall();
        test_shared();
        test_reset_mid();
        test_stray();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
